// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 decryptor, one round per clock.
// The inverse key schedule is computed on the fly.
// Flow: IDLE -> KEXP (10 forward key steps to reach rk10) -> ROUND (10 inverse rounds) -> DONE.
// Optional macro AES_KEY_CACHE_EN caches the last key and its rk10.
// When a new block arrives under the cached key, KEXP is skipped.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   ct/key valid            in_ready   block accepts ct/key this cycle
//   ct         ciphertext (byte 0 = ct[127:120])
//   key        cipher key, same byte order
//   out_valid  pt valid, held until out_ready
//   out_ready  consumer accepts pt
//   pt         plaintext
//   busy       high in any state except IDLE
// Parameter CLEAR_ON_DONE: 1 scrubs state/round-key registers on the output handshake.
module aes128_decrypt_iter #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StKexp, StRound, StDone} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); 0 maps to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // InvShiftRows and InvSubBytes fused; byte (row r, col c) sits at index 4c+r.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox_inv(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_t         r_state, w_state_d;
    logic [127:0]   r_st, r_rk, r_pt;
    logic [3:0]     r_cnt;
    logic           r_out_valid;
    logic           w_hit;
    logic [31:0]    w_sw_in, w_sw_out;
    logic [127:0]   w_rk_next, w_rk_prev, w_ark, w_round;

`ifdef AES_KEY_CACHE_EN
    logic [127:0]   r_cache_key, r_cache_rk10;
    logic           r_cache_vld;
    assign w_hit = r_cache_vld && (key == r_cache_key);
`else
    assign w_hit = 1'b0;
`endif

    assign pt        = r_pt;
    assign out_valid = r_out_valid;

    // One shared 4-byte S-box row.
    // KEXP feeds it the current w3; ROUND feeds it the recovered previous w3 (= w3' ^ w2').
    always_comb begin
        w_sw_in  = (r_state == StKexp) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);
        w_sw_out = {sbox_fwd(w_sw_in[23:16]), sbox_fwd(w_sw_in[15:8]),
                    sbox_fwd(w_sw_in[7:0]), sbox_fwd(w_sw_in[31:24])} ^ {rcon(r_cnt), 24'h0};
        w_rk_next[127:96] = r_rk[127:96] ^ w_sw_out;
        w_rk_next[95:64]  = r_rk[95:64] ^ w_rk_next[127:96];
        w_rk_next[63:32]  = r_rk[63:32] ^ w_rk_next[95:64];
        w_rk_next[31:0]   = r_rk[31:0] ^ w_rk_next[63:32];
        w_rk_prev[127:96] = r_rk[127:96] ^ w_sw_out;
        w_rk_prev[95:64]  = r_rk[95:64] ^ r_rk[127:96];
        w_rk_prev[63:32]  = r_rk[63:32] ^ r_rk[95:64];
        w_rk_prev[31:0]   = r_rk[31:0] ^ r_rk[63:32];
        w_ark   = inv_sub_shift(r_st) ^ w_rk_prev;
        w_round = (r_cnt != 4'd0) ? inv_mix(w_ark) : w_ark;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_d = w_hit ? StRound : StKexp;
            end
            StKexp:  if (r_cnt == 4'd9) w_state_d = StRound;
            StRound: if (r_cnt == 4'd0) w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_st        <= '0;
            r_rk        <= '0;
            r_pt        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            r_cache_key  <= '0;
            r_cache_rk10 <= '0;
            r_cache_vld  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_st  <= ct;
                        r_rk  <= key;
                        r_cnt <= 4'd0;
`ifdef AES_KEY_CACHE_EN
                        if (w_hit) begin
                            r_st  <= ct ^ r_cache_rk10;
                            r_rk  <= r_cache_rk10;
                            r_cnt <= 4'd9;
                        end else begin
                            // Key captured now; marked valid only once rk10 exists.
                            r_cache_key <= key;
                            r_cache_vld <= 1'b0;
                        end
`endif
                    end
                end
                StKexp: begin
                    r_rk  <= w_rk_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_st  <= r_st ^ w_rk_next;
                        r_cnt <= 4'd9;
`ifdef AES_KEY_CACHE_EN
                        r_cache_rk10 <= w_rk_next;
                        r_cache_vld  <= 1'b1;
`endif
                    end
                end
                StRound: begin
                    r_rk  <= w_rk_prev;
                    r_st  <= w_round;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_pt        <= w_round;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (CLEAR_ON_DONE) begin
                            r_st <= '0;
                            r_rk <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
